// File: rtl/cc_regbank_pkg.sv
// ============================================================================
// Module      : cc_regbank_pkg
// Description : Shared constants, types and helpers for the cc_regbank
//               register bank (index width, data width, PC location/step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package cc_regbank_pkg;

  localparam int DATAWIDTH_BUS  = 4;
  localparam int DATAWIDTH_DATA = 32;
  localparam int NUM_REGS       = 12;

  typedef logic [DATAWIDTH_BUS-1:0]  reg_idx_t;
  typedef logic [DATAWIDTH_DATA-1:0] reg_data_t;

  localparam reg_idx_t  ZERO_INDEX     = reg_idx_t'(0);
  localparam reg_idx_t  PC_INDEX       = reg_idx_t'(11);
  localparam reg_idx_t  NUM_REGS_IDX   = reg_idx_t'(NUM_REGS);
  localparam reg_data_t PC_STEP        = reg_data_t'(4);
  // Value driven onto the B-bus for indices with no register behind them.
  localparam reg_data_t OOR_READ_VALUE = reg_data_t'(0);

  // True for indices that map onto a real, writable register.
  function automatic logic idx_writable(reg_idx_t idx);
    return (idx != ZERO_INDEX) && (idx < NUM_REGS_IDX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cc_regbank_bus_if.sv
// ============================================================================
// Module      : cc_regbank_bus_if
// Description : B-bus read / C-bus write / PC-increment signal bundle of the
//               register bank. master = bus-select side, slave = bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface cc_regbank_bus_if;
  import cc_regbank_pkg::*;

  reg_idx_t  CC_REGBANK_readSel_InBUS;
  logic      CC_REGBANK_readReq_In;
  reg_idx_t  CC_REGBANK_writeSel_InBUS;
  logic      CC_REGBANK_writeEn_In;
  reg_data_t CC_REGBANK_data_InBUS;
  logic      CC_REGBANK_pcInc_In;
  reg_data_t CC_REGBANK_data_OutBUS;
  logic      CC_REGBANK_valid_Out;
  reg_data_t CC_REGBANK_pc_OutBUS;

  modport master (
    output CC_REGBANK_readSel_InBUS,
    output CC_REGBANK_readReq_In,
    output CC_REGBANK_writeSel_InBUS,
    output CC_REGBANK_writeEn_In,
    output CC_REGBANK_data_InBUS,
    output CC_REGBANK_pcInc_In,
    input  CC_REGBANK_data_OutBUS,
    input  CC_REGBANK_valid_Out,
    input  CC_REGBANK_pc_OutBUS
  );

  modport slave (
    input  CC_REGBANK_readSel_InBUS,
    input  CC_REGBANK_readReq_In,
    input  CC_REGBANK_writeSel_InBUS,
    input  CC_REGBANK_writeEn_In,
    input  CC_REGBANK_data_InBUS,
    input  CC_REGBANK_pcInc_In,
    output CC_REGBANK_data_OutBUS,
    output CC_REGBANK_valid_Out,
    output CC_REGBANK_pc_OutBUS
  );

endinterface

`default_nettype wire

// File: rtl/cc_regbank_reg.sv
// ============================================================================
// Module      : cc_regbank_reg
// Description : Single data-width storage register with asynchronous
//               active-low clear and synchronous load enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cc_regbank_reg
  import cc_regbank_pkg::*;
(
  input  wire logic      i_clk,
  input  wire logic      i_rst_n,
  input  wire logic      i_load,
  input  wire reg_data_t i_d,
  output reg_data_t      o_q
);

  reg_data_t r_q;

  // Capture i_d when loaded, otherwise hold; cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/cc_regbank_bus.sv
// ============================================================================
// Module      : cc_regbank_bus
// Description : 12-entry register bank. Register 0 reads as zero, register 11
//               is the PC with a +4 increment path. B-bus read data is
//               registered (one-cycle latency) with a valid strobe.
//               Optional build macro: CC_REGBANK_BYPASS_EN forwards same-cycle
//               write data / incremented PC onto the read path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cc_regbank_bus
  import cc_regbank_pkg::*;
(
  input  wire logic       CC_REGBANK_CLOCK_50,
  input  wire logic       CC_REGBANK_RESET_InLow,
  cc_regbank_bus_if.slave bus
);

  reg_data_t w_regs [NUM_REGS];
  reg_data_t w_pc_next;
  logic      w_wr_ok;
  reg_data_t w_rd_data;
  reg_data_t r_data;
  logic      r_valid;

  assign w_regs[0] = '0;
  assign w_wr_ok   = bus.CC_REGBANK_writeEn_In && idx_writable(bus.CC_REGBANK_writeSel_InBUS);
  assign w_pc_next = w_regs[PC_INDEX] + PC_STEP;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
    logic      w_hit;
    logic      w_load;
    reg_data_t w_d;

    assign w_hit = w_wr_ok && (bus.CC_REGBANK_writeSel_InBUS == reg_idx_t'(i));

    if (i == int'(PC_INDEX)) begin : g_pc
      // Explicit C-bus write takes priority over the increment.
      assign w_load = w_hit || bus.CC_REGBANK_pcInc_In;
      assign w_d    = w_hit ? bus.CC_REGBANK_data_InBUS : w_pc_next;
    end else begin : g_gpr
      assign w_load = w_hit;
      assign w_d    = bus.CC_REGBANK_data_InBUS;
    end

    cc_regbank_reg u_reg (
      .i_clk   (CC_REGBANK_CLOCK_50),
      .i_rst_n (CC_REGBANK_RESET_InLow),
      .i_load  (w_load),
      .i_d     (w_d),
      .o_q     (w_regs[i])
    );
  end

  // B-bus read mux: unimplemented indices fall through to the default value.
  always_comb begin
    w_rd_data = OOR_READ_VALUE;
    if (bus.CC_REGBANK_readSel_InBUS < NUM_REGS_IDX) begin
      w_rd_data = w_regs[bus.CC_REGBANK_readSel_InBUS];
    end
`ifdef CC_REGBANK_BYPASS_EN
    if (w_wr_ok && (bus.CC_REGBANK_writeSel_InBUS == bus.CC_REGBANK_readSel_InBUS)) begin
      w_rd_data = bus.CC_REGBANK_data_InBUS;
    end else if ((bus.CC_REGBANK_readSel_InBUS == PC_INDEX) && bus.CC_REGBANK_pcInc_In) begin
      w_rd_data = w_pc_next;
    end
`endif
  end

  // Read pipeline stage: data holds when idle, valid pulses per request.
  always_ff @(posedge CC_REGBANK_CLOCK_50 or negedge CC_REGBANK_RESET_InLow) begin
    if (!CC_REGBANK_RESET_InLow) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.CC_REGBANK_readReq_In;
      if (bus.CC_REGBANK_readReq_In) begin
        r_data <= w_rd_data;
      end
    end
  end

  assign bus.CC_REGBANK_data_OutBUS = r_data;
  assign bus.CC_REGBANK_valid_Out   = r_valid;
  assign bus.CC_REGBANK_pc_OutBUS   = w_regs[PC_INDEX];

endmodule

`default_nettype wire
